// File: rtl/tick_counter.sv
// tick_counter
//
// Turns the divided square wave from the clock divider into a timebase in the
// clk_in domain. slow_in is treated as asynchronous data: it is synchronized,
// edge-detected into a one-cycle tick strobe, and the ticks are counted by a
// start/stop controlled counter with a programmable terminal count.
//
// Build option:
//   TICK_BOTH_EDGES_EN  when defined, both rising and falling synchronized
//                       edges produce a tick; otherwise rising edges only.
//
// Parameters:
//   CNT_W        width of period and count
//   SYNC_STAGES  synchronizer depth, legal range 2..4
//
// Ports:
//   clk_in   system clock, the only clock in the block
//   rst      synchronous active-high reset
//   slow_in  divided square wave, asynchronous to clk_in
//   start    level; requests IDLE -> RUN
//   stop     level; requests RUN -> IDLE, wins over start
//   period   terminal count, sampled every cycle
//   tick     one-cycle strobe per detected slow_in edge
//   wrap     one-cycle strobe when the count passes its terminal value
//   count    current tick count
//   running  high while in RUN
//
// All outputs are registered.

module tick_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             wrap,
  output logic [CNT_W-1:0] count,
  output logic             running
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e state_q;

  // Synchronizer chain; bit 0 is the first stage facing slow_in.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_last;
  logic                   edge_det;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q <= sync_last;
    end
  end

  // prev_q resets to 0, so a slow_in that is already high at reset release
  // still produces exactly one tick.
`ifdef TICK_BOTH_EDGES_EN
  assign edge_det = sync_last ^ prev_q;
`else
  assign edge_det = sync_last & ~prev_q;
`endif

  // Control FSM and counter. tick, wrap, count and running are all updated
  // here so every output comes straight from a flop.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= StIdle;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      count   <= '0;
      running <= 1'b0;
    end else begin
      // tick is independent of the FSM state.
      tick <= edge_det;
      wrap <= 1'b0;

      unique case (state_q)
        StIdle: begin
          running <= 1'b0;
          // stop wins when both are asserted.
          if (start && !stop) begin
            state_q <= StRun;
            running <= 1'b1;
            count   <= '0;
          end
        end

        StRun: begin
          running <= 1'b1;
          if (stop) begin
            // An edge on the transition cycle is not counted; count holds.
            state_q <= StIdle;
            running <= 1'b0;
          end else if (edge_det) begin
            // >= rather than == so that lowering period below the current
            // count wraps on the next tick instead of running past it.
            if (count >= period) begin
              count <= '0;
              wrap  <= 1'b1;
            end else begin
              count <= count + CntOne;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter. Each counted slow_in edge pushes the
// expected tick (cycle, count, wrap, running) into a scoreboard; a monitor on
// the falling clock edge pops and compares when the tick is due.
// Honours TICK_BOTH_EDGES_EN in the same way as the design.

module tb_tick_counter;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         slow_in = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] period = '0;
  logic         tick;
  logic         wrap;
  logic [W-1:0] count;
  logic         running;

  tick_counter #(
    .CNT_W      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .slow_in(slow_in),
    .start  (start),
    .stop   (stop),
    .period (period),
    .tick   (tick),
    .wrap   (wrap),
    .count  (count),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [W-1:0] cnt;
    logic       wrp;
    logic       run;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_push = 0;
  int exp_wraps = 0;
  int seen_wraps = 0;

  // Abstract model state: run flag and tick count.
  bit m_run = 1'b0;
  int m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Monitor: outputs are stable on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (wrap === 1'b1) seen_wraps++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_eq("tick", tick, 1'b1);
      check_eq("tick_count", count, e.cnt);
      check_eq("tick_wrap", wrap, e.wrp);
      check_eq("tick_running", running, e.run);
    end else begin
      if (tick === 1'b1) check_eq("tick_spurious", tick, 1'b0);
      if (wrap === 1'b1) check_eq("wrap_without_tick", wrap, 1'b0);
    end
  end

  // Flip slow_in at a falling edge and wait 'half' cycles. A counted edge
  // pushes its expected tick. With stop_on_edge, stop is raised so that it is
  // sampled on the same clock edge that registers the tick.
  task automatic toggle(input int half, input bit stop_on_edge);
    bit   rising;
    bit   counted;
    exp_t e;
    rising  = (slow_in == 1'b0);
    slow_in = rising;
`ifdef TICK_BOTH_EDGES_EN
    counted = 1'b1;
`else
    counted = rising;
`endif
    if (counted) begin
      e.due = cyc + 1 + S;
      e.wrp = 1'b0;
      if (m_run && !stop_on_edge) begin
        if (m_cnt >= int'(period)) begin
          m_cnt = 0;
          e.wrp = 1'b1;
          exp_wraps++;
        end else begin
          m_cnt++;
        end
      end
      if (stop_on_edge) m_run = 1'b0;
      e.cnt = m_cnt[W-1:0];
      e.run = m_run;
      sb.push_back(e);
      n_push++;
    end
    if (stop_on_edge) begin
      repeat (S) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (half - int'(S) - 1) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_run = 1'b1;
    m_cnt = 0;
    check_eq("start_running", running, 1'b1);
    check_eq("start_count_clr", count, '0);
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    m_run = 1'b0;
    check_eq("stop_running", running, 1'b0);
    check_eq("stop_count_hold", count, m_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int e0;
    int p0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_tick", tick, 1'b0);
    check_eq("rst_wrap", wrap, 1'b0);
    check_eq("rst_count", count, '0);
    check_eq("rst_running", running, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Idle: ticks still flow, nothing counts.
    period = 16'd5;
    for (int i = 0; i < 6; i++) toggle(8, 1'b0);
    check_eq("idle_running", running, 1'b0);

    // period 3, 10 rising edges.
    period = 16'd3;
    start_pulse();
    for (int i = 0; i < 20; i++) toggle(5, 1'b0);

    // Reach count 5, then lower period below it.
    period = 16'd100;
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == 5) break;
      toggle(4, 1'b0);
    end
    check_eq("count_at_5", count, 16'd5);
    period = 16'd2;
    p0 = n_push;
    for (int i = 0; i < 3; i++) begin
      if (n_push != p0) break;
      toggle(4, 1'b0);
    end

    // start and stop together in IDLE stays IDLE.
    stop_pulse();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_eq("start_stop_idle", running, 1'b0);
    @(negedge clk);
    check_eq("start_stop_idle2", running, 1'b0);

    // Stop on a tick cycle with count 2: tick seen, not counted.
    period = 16'd10;
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      if (m_cnt == 2) break;
      toggle(4, 1'b0);
    end
`ifndef TICK_BOTH_EDGES_EN
    if (slow_in == 1'b1) toggle(4, 1'b0);
`endif
    toggle(6, 1'b1);
    check_eq("stop_tick_running", running, 1'b0);
    check_eq("stop_tick_count", count, 16'd2);

    // period 0: every tick wraps, count stays 0.
    period = 16'd0;
    start_pulse();
    for (int i = 0; i < 6; i++) toggle(4, 1'b0);
    stop_pulse();

    // Reset mid-run with count 7 and slow_in high.
    period = 16'd20;
    start_pulse();
    for (int i = 0; i < 40; i++) begin
      if (m_cnt >= 7 && slow_in == 1'b1) break;
      toggle(4, 1'b0);
    end
    check_eq("pre_rst_slow", slow_in, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tick", tick, 1'b0);
    check_eq("mid_rst_wrap", wrap, 1'b0);
    check_eq("mid_rst_count", count, '0);
    check_eq("mid_rst_running", running, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    m_run = 1'b0;
    m_cnt = 0;
    begin
      exp_t e;
      e.due = cyc + 1 + S;
      e.cnt = '0;
      e.wrp = 1'b0;
      e.run = 1'b0;
      sb.push_back(e);
    end
    repeat (S + 6) @(negedge clk);

    // period 1, 4 full slow_in cycles.
    period = 16'd1;
    start_pulse();
    w0 = seen_wraps;
    e0 = exp_wraps;
    for (int i = 0; i < 8; i++) toggle(4, 1'b0);
    repeat (4) @(negedge clk);
`ifdef TICK_BOTH_EDGES_EN
    check_eq("p1_wraps", seen_wraps - w0, 4);
`else
    check_eq("p1_wraps", seen_wraps - w0, 2);
`endif
    check_eq("p1_wraps_model", seen_wraps - w0, exp_wraps - e0);

    repeat (10) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("wrap_total", seen_wraps, exp_wraps);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
